// File: rtl/lpc_frame_loader.sv
`default_nettype none
// ============================================================================
// lpc_frame_loader : assembles 14-word LPC frames into a shadow buffer and
//                    swaps them into the active decoder registers on frame
//                    boundaries counted in sample strobes.
// Revision: 1.0
// ============================================================================
module lpc_frame_loader #(
  parameter int NCOEF  = 11,
  parameter int NWORDS = 3 + NCOEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                v,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sof,
  input  logic [15:0]         in_data,
  output logic                voiced,
  output logic [15:0]         pulserate,
  output logic [15:0]         lpcrate,
  output logic [16*NCOEF-1:0] coef,
  output logic                act_valid,
  output logic                frame_start,
  output logic                underrun,
  output logic                frame_err
);

  localparam int            IW         = $clog2(NWORDS);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NWORDS - 1);
  localparam logic [0:0]    ST_LOADING = 1'b0;
  localparam logic [0:0]    ST_PENDING = 1'b1;

  logic [0:0]         state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               sh_voiced_q;
  logic [15:0]        sh_word_q [1:NWORDS-1];
  logic               voiced_q;
  logic [15:0]        pulserate_q, lpcrate_q;
  logic [16*NCOEF-1:0] coef_q;
  logic               act_valid_q, frame_start_q, underrun_q, frame_err_q;

  logic               w_accept, w_resync, w_last, w_pending;
  logic               w_boundary, w_swap, w_underrun;
  logic [IW-1:0]      w_widx;
  logic [15:0]        w_lr_m1;

  always_comb begin
    w_accept   = in_valid && in_ready_q;
    w_resync   = w_accept && in_sof && (idx_q != '0);
    w_widx     = w_resync ? '0 : idx_q;
    w_last     = w_accept && (w_widx == LAST_IDX);
    // lpcrate of 0 or 1 makes every strobe a boundary
    w_lr_m1    = (lpcrate_q == 16'd0) ? 16'd0 : lpcrate_q - 16'd1;
    w_boundary = v && (cnt_q >= w_lr_m1);
    w_pending  = (state_q == ST_PENDING);
    w_swap     = w_pending && (!act_valid_q || w_boundary);
    w_underrun = act_valid_q && w_boundary && !w_pending;
  end

  // Load state machine: register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOADING;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Load state machine: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOADING: if (w_last) state_d = ST_PENDING;
      ST_PENDING: if (w_swap) state_d = ST_LOADING;
      default:    state_d = ST_LOADING;
    endcase
  end

  // Load state machine: outputs
  always_comb begin
    in_ready_d = (state_d == ST_LOADING);
    idx_d      = idx_q;
    if (w_accept) idx_d = w_last ? '0 : w_widx + IW'(1);
    cnt_d = cnt_q;
    if (w_swap && !act_valid_q) cnt_d = 16'd0;
    else if (w_boundary)        cnt_d = 16'd0;
    else if (v)                 cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q         <= '0;
      cnt_q         <= '0;
      sh_voiced_q   <= 1'b0;
      for (int i = 1; i < NWORDS; i++) sh_word_q[i] <= '0;
      voiced_q      <= 1'b0;
      pulserate_q   <= '0;
      lpcrate_q     <= '0;
      coef_q        <= '0;
      act_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      frame_start_q <= w_swap;
      underrun_q    <= w_underrun;
      frame_err_q   <= w_resync;
      if (w_accept) begin
        if (w_widx == '0) sh_voiced_q       <= in_data[0];
        else              sh_word_q[w_widx] <= in_data;
      end
      if (w_swap) begin
        act_valid_q <= 1'b1;
        voiced_q    <= sh_voiced_q;
        pulserate_q <= sh_word_q[1];
        lpcrate_q   <= sh_word_q[2];
        for (int k = 0; k < NCOEF; k++) coef_q[16*k +: 16] <= sh_word_q[3+k];
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign voiced      = voiced_q;
  assign pulserate   = pulserate_q;
  assign lpcrate     = lpcrate_q;
  assign coef        = coef_q;
  assign act_valid   = act_valid_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign frame_err   = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lpc_frame_loader.sv
`default_nettype none
// ============================================================================
// tb_lpc_frame_loader : table, directed and randomized checks of the LPC
//                       frame loader against a frame-level reference model.
// Revision: 1.0
// ============================================================================
module tb_lpc_frame_loader;

  localparam int NCOEF = 11;
  localparam int NW    = 3 + NCOEF;
  localparam int CW    = 16 * NCOEF;

  logic          clk, rst, v, in_valid, in_ready, in_sof;
  logic [15:0]   in_data;
  logic          voiced, act_valid, frame_start, underrun, frame_err;
  logic [15:0]   pulserate, lpcrate;
  logic [CW-1:0] coef;

  int n_tests = 0;
  int n_fail  = 0;

  lpc_frame_loader #(.NCOEF(NCOEF), .NWORDS(NW)) dut (
    .clk(clk), .rst(rst), .v(v), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_data(in_data), .voiced(voiced), .pulserate(pulserate),
    .lpcrate(lpcrate), .coef(coef), .act_valid(act_valid),
    .frame_start(frame_start), .underrun(underrun), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level reference model
  bit          m_ready, m_pending, m_valid, m_voiced, m_fs, m_ur, m_fe;
  int          m_pos;
  int unsigned m_cnt;
  logic [15:0] m_pr, m_lr;
  logic [CW-1:0] m_coef;
  logic [15:0] m_frame [NW];

  function automatic void model_reset();
    m_ready = 0; m_pending = 0; m_valid = 0; m_voiced = 0;
    m_fs = 0; m_ur = 0; m_fe = 0; m_pos = 0; m_cnt = 0;
    m_pr = '0; m_lr = '0; m_coef = '0;
    for (int i = 0; i < NW; i++) m_frame[i] = '0;
  endfunction

  function automatic void model_step();
    bit acc, bnd, swap;
    int unsigned period;
    if (rst) begin
      model_reset();
      return;
    end
    acc    = in_valid && m_ready;
    period = (m_lr <= 16'd1) ? 1 : int'(m_lr);
    bnd    = v && (m_cnt + 1 >= period);
    swap   = m_pending && (!m_valid || bnd);
    m_ur   = m_valid && bnd && !m_pending;
    m_fs   = swap;
    m_fe   = 0;
    if (swap && !m_valid) m_cnt = 0;
    else if (bnd)         m_cnt = 0;
    else if (v)           m_cnt = m_cnt + 1;
    if (swap) begin
      m_voiced = m_frame[0][0];
      m_pr     = m_frame[1];
      m_lr     = m_frame[2];
      for (int k = 0; k < NCOEF; k++) m_coef[16*k +: 16] = m_frame[3+k];
      m_valid   = 1;
      m_pending = 0;
    end
    if (acc) begin
      if (in_sof && m_pos != 0) begin
        m_fe  = 1;
        m_pos = 0;
      end
      m_frame[m_pos] = in_data;
      m_pos = m_pos + 1;
      if (m_pos == NW) begin
        m_pos     = 0;
        m_pending = 1;
      end
    end
    m_ready = !m_pending;
  endfunction

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    chk("in_ready",    CW'(in_ready),    CW'(m_ready));
    chk("voiced",      CW'(voiced),      CW'(m_voiced));
    chk("pulserate",   CW'(pulserate),   CW'(m_pr));
    chk("lpcrate",     CW'(lpcrate),     CW'(m_lr));
    chk("coef",        coef,             m_coef);
    chk("act_valid",   CW'(act_valid),   CW'(m_valid));
    chk("frame_start", CW'(frame_start), CW'(m_fs));
    chk("underrun",    CW'(underrun),    CW'(m_ur));
    chk("frame_err",   CW'(frame_err),   CW'(m_fe));
  endtask

  task automatic do_cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic send_word(input logic sof, input logic [15:0] d, input logic vv);
    in_valid = 1'b1; in_sof = sof; in_data = d; v = vv;
    do_cycle();
    in_valid = 1'b0; in_sof = 1'b0; v = 1'b0;
  endtask

  task automatic idle(input logic vv);
    in_valid = 1'b0; in_sof = 1'b0; v = vv;
    do_cycle();
    v = 1'b0;
  endtask

  task automatic send_frame(input logic vc, input logic [15:0] pr, input logic [15:0] lr,
                            input logic [15:0] base);
    send_word(1'b1, {15'd0, vc}, 1'b0);
    send_word(1'b0, pr, 1'b0);
    send_word(1'b0, lr, 1'b0);
    for (int k = 0; k < NCOEF; k++) send_word(1'b0, base + 16'(k), 1'b0);
  endtask

  typedef struct {
    logic        v, valid, sof;
    logic [15:0] data;
    logic        e_ready, e_av, e_fs, e_ur, e_fe;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // First frame: 14 accepts, then swap with no strobe needed
    for (int i = 0; i < 16; i++) begin
      tbl[i].v     = 1'b0;
      tbl[i].valid = (i < NW);
      tbl[i].sof   = (i == 0);
      tbl[i].data  = (i == 0) ? 16'd1 : (i == 1) ? 16'd80 : (i == 2) ? 16'd4 : 16'(i - 2);
      tbl[i].e_ready = (i != NW - 1);
      tbl[i].e_av    = (i >= NW);
      tbl[i].e_fs    = (i == NW);
      tbl[i].e_ur    = 1'b0;
      tbl[i].e_fe    = 1'b0;
    end

    rst = 1'b1; v = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    model_reset();
    do_cycle();
    do_cycle();
    rst = 1'b0;
    do_cycle();
    chk("reset_release_ready", CW'(in_ready), CW'(1'b1));
    chk("reset_act_valid", CW'(act_valid), CW'(1'b0));

    for (int i = 0; i < 16; i++) begin
      v = tbl[i].v; in_valid = tbl[i].valid; in_sof = tbl[i].sof; in_data = tbl[i].data;
      do_cycle();
      chk($sformatf("t1_ready[%0d]", i), CW'(in_ready),    CW'(tbl[i].e_ready));
      chk($sformatf("t1_av[%0d]", i),    CW'(act_valid),   CW'(tbl[i].e_av));
      chk($sformatf("t1_fs[%0d]", i),    CW'(frame_start), CW'(tbl[i].e_fs));
      chk($sformatf("t1_ur[%0d]", i),    CW'(underrun),    CW'(tbl[i].e_ur));
      chk($sformatf("t1_fe[%0d]", i),    CW'(frame_err),   CW'(tbl[i].e_fe));
      if (i == NW) begin
        chk("t1_voiced", CW'(voiced), CW'(1'b1));
        chk("t1_pr", CW'(pulserate), CW'(16'd80));
        chk("t1_lr", CW'(lpcrate), CW'(16'd4));
        chk("t1_coef0", CW'(coef[15:0]), CW'(16'd1));
        chk("t1_coef10", CW'(coef[CW-1 -: 16]), CW'(16'd11));
      end
    end
    in_valid = 1'b0; in_sof = 1'b0;

    // Frame B waits for the 4th strobe
    send_frame(1'b0, 16'd100, 16'd4, 16'd100);
    chk("t2_pending_ready", CW'(in_ready), CW'(1'b0));
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk("t2_no_swap_yet", CW'(frame_start), CW'(1'b0));
    end
    idle(1'b1);
    chk("t2_fs", CW'(frame_start), CW'(1'b1));
    chk("t2_pr", CW'(pulserate), CW'(16'd100));
    chk("t2_voiced", CW'(voiced), CW'(1'b0));
    chk("t2_ready_back", CW'(in_ready), CW'(1'b1));

    // Underrun twice, 4 strobes apart
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) begin
        idle(1'b1);
        chk("t3_underrun", CW'(underrun), CW'(i == 3));
        chk("t3_hold_pr", CW'(pulserate), CW'(16'd100));
        chk("t3_no_fs", CW'(frame_start), CW'(1'b0));
      end

    // Resync after 5 words
    send_word(1'b1, 16'd1, 1'b0);
    send_word(1'b0, 16'd200, 1'b0);
    send_word(1'b0, 16'd4, 1'b0);
    send_word(1'b0, 16'd7, 1'b0);
    send_word(1'b0, 16'd8, 1'b0);
    send_word(1'b1, 16'd0, 1'b0);
    chk("t4_frame_err", CW'(frame_err), CW'(1'b1));
    send_word(1'b0, 16'd300, 1'b0);
    chk("t4_err_clear", CW'(frame_err), CW'(1'b0));
    send_word(1'b0, 16'd4, 1'b0);
    for (int k = 0; k < NCOEF; k++) send_word(1'b0, 16'd300 + 16'(k), 1'b0);
    chk("t4_pending", CW'(in_ready), CW'(1'b0));
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("t4_fs", CW'(frame_start), CW'(1'b1));
    chk("t4_voiced", CW'(voiced), CW'(1'b0));
    chk("t4_pr", CW'(pulserate), CW'(16'd300));

    // Final word coincides with boundary strobe
    send_word(1'b1, 16'd1, 1'b0);
    send_word(1'b0, 16'd500, 1'b0);
    send_word(1'b0, 16'd20, 1'b0);
    for (int k = 0; k < NCOEF - 1; k++) send_word(1'b0, 16'd500 + 16'(k), 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    send_word(1'b0, 16'd510, 1'b1);
    chk("t5_underrun", CW'(underrun), CW'(1'b1));
    chk("t5_no_fs", CW'(frame_start), CW'(1'b0));
    chk("t5_pending", CW'(in_ready), CW'(1'b0));
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      chk("t5_wait", CW'(frame_start), CW'(1'b0));
    end
    idle(1'b1);
    chk("t5_fs", CW'(frame_start), CW'(1'b1));
    chk("t5_lr", CW'(lpcrate), CW'(16'd20));

    // Asynchronous reset while pending
    send_frame(1'b1, 16'd600, 16'd30, 16'd600);
    for (int i = 0; i < 7; i++) idle(1'b1);
    chk("t6_pre_av", CW'(act_valid), CW'(1'b1));
    rst = 1'b1;
    #1;
    model_reset();
    check_model();
    chk("t6_rst_voiced", CW'(voiced), CW'(1'b0));
    chk("t6_rst_lr", CW'(lpcrate), CW'(16'd0));
    chk("t6_rst_coef", coef, '0);
    chk("t6_rst_av", CW'(act_valid), CW'(1'b0));
    do_cycle();
    rst = 1'b0;
    do_cycle();
    chk("t6_ready", CW'(in_ready), CW'(1'b1));
    chk("t6_av", CW'(act_valid), CW'(1'b0));

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 499) == 0);
      v        = ($urandom_range(0, 2) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_sof   = (m_pos == 0) ? 1'b1 : ($urandom_range(0, 39) == 0);
      in_data  = (m_pos == 2) ? 16'($urandom_range(0, 6)) : 16'($urandom);
      do_cycle();
    end
    rst = 1'b0; v = 1'b0; in_valid = 1'b0; in_sof = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
